// File: rtl/m_ext_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Define DIV_EARLY_OUT_EN to finish in one cycle when |dividend| < |divisor|.

`ifndef XLEN
`define XLEN 32
`endif

package m_ext_divider_pkg;
  typedef struct packed {
    logic [`XLEN-1:0] alu_operand_1;
    logic [`XLEN-1:0] alu_operand_2;
    logic [2:0]       alu_d_ops;
  } type_exe2div_s;
endpackage

module m_ext_divider
  import m_ext_divider_pkg::*;
#(
  parameter int unsigned XLEN_P = `XLEN,
  parameter int unsigned CNT_W  = $clog2(XLEN_P) + 1
) (
  input  logic              rst_n,
  input  logic              clk,
  input  type_exe2div_s     exe2div_i,
  input  logic              pipe_stall_i,
  input  logic              kill_i,
  output logic [XLEN_P-1:0] div_result_o,
  output logic              div_done_o,
  output logic              div_stall_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [2:0] OpDiv  = 3'd1;
  localparam logic [2:0] OpDivu = 3'd2;
  localparam logic [2:0] OpRem  = 3'd3;
  localparam logic [2:0] OpRemu = 3'd4;

  localparam logic [XLEN_P-1:0] MinNeg = {1'b1, {(XLEN_P-1){1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              op_rem_q, op_rem_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic [XLEN_P-1:0] rem_q, rem_d;
  logic [XLEN_P-1:0] quo_q, quo_d;
  logic [XLEN_P-1:0] divisor_q, divisor_d;
  logic [XLEN_P-1:0] result_q, result_d;
  logic              done_q, done_d;

  logic [2:0]        req_op;
  logic              req_valid, req_signed, req_rem;
  logic [XLEN_P-1:0] dividend, divisor;
  logic              sign_a_req, sign_b_req;
  logic [XLEN_P-1:0] mag_a, mag_b;
  logic              div_zero, ovf, early;

  logic [XLEN_P:0]   rem_sh, trial;
  logic [XLEN_P-1:0] rem_step, quo_step, q_fix, r_fix;

  // Request decode; op codes 5-7 behave as NONE.
  always_comb begin
    req_op     = exe2div_i.alu_d_ops;
    dividend   = exe2div_i.alu_operand_1;
    divisor    = exe2div_i.alu_operand_2;
    req_valid  = (req_op != 3'd0) && (req_op <= OpRemu);
    req_signed = (req_op == OpDiv) || (req_op == OpRem);
    req_rem    = (req_op == OpRem) || (req_op == OpRemu);
    sign_a_req = req_signed & dividend[XLEN_P-1];
    sign_b_req = req_signed & divisor[XLEN_P-1];
    mag_a      = sign_a_req ? ('0 - dividend) : dividend;
    mag_b      = sign_b_req ? ('0 - divisor) : divisor;
    div_zero   = (divisor == '0);
    ovf        = req_signed && (dividend == MinNeg) && (divisor == '1);
`ifdef DIV_EARLY_OUT_EN
    early      = (mag_a < mag_b);
`else
    early      = 1'b0;
`endif
  end

  // One restoring step; the shifted-out quotient MSB keeps the 33-bit trial exact.
  always_comb begin
    rem_sh = {rem_q, quo_q[XLEN_P-1]};
    trial  = rem_sh - {1'b0, divisor_q};
    if (!trial[XLEN_P]) begin
      rem_step = trial[XLEN_P-1:0];
      quo_step = {quo_q[XLEN_P-2:0], 1'b1};
    end else begin
      rem_step = rem_sh[XLEN_P-1:0];
      quo_step = {quo_q[XLEN_P-2:0], 1'b0};
    end
    q_fix = (sign_a_q ^ sign_b_q) ? ('0 - quo_step) : quo_step;
    r_fix = sign_a_q ? ('0 - rem_step) : rem_step;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_rem_d  = op_rem_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    result_d  = result_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid && !kill_i) begin
          op_rem_d  = req_rem;
          sign_a_d  = sign_a_req;
          sign_b_d  = sign_b_req;
          quo_d     = mag_a;
          divisor_d = mag_b;
          rem_d     = '0;
          cnt_d     = CNT_W'(XLEN_P);
          if (div_zero) begin
            state_d  = StDone;
            result_d = req_rem ? dividend : '1;
          end else if (ovf) begin
            state_d  = StDone;
            result_d = req_rem ? '0 : MinNeg;
          end else if (early) begin
            state_d  = StDone;
            result_d = req_rem ? dividend : '0;
          end else begin
            state_d  = StCalc;
          end
        end
      end
      StCalc: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d  = StDone;
          result_d = op_rem_q ? r_fix : q_fix;
        end
      end
      StDone: begin
        if (!pipe_stall_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (kill_i) begin
      state_d  = StIdle;
      result_d = result_q;
    end

    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_rem_q  <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_rem_q  <= op_rem_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

  assign div_result_o = result_q;
  assign div_done_o   = done_q;
  assign div_stall_o  = req_valid & ~done_q & ~kill_i;

endmodule

// File: tb/tb_m_ext_divider.sv
// Self-checking bench for m_ext_divider: directed RV32M cases plus random divides
// compared against an arithmetic reference model.

module tb_m_ext_divider;
  import m_ext_divider_pkg::*;

  localparam logic [2:0] OpNone = 3'd0;
  localparam logic [2:0] OpDiv  = 3'd1;
  localparam logic [2:0] OpDivu = 3'd2;
  localparam logic [2:0] OpRem  = 3'd3;
  localparam logic [2:0] OpRemu = 3'd4;

  logic          clk;
  logic          rst_n;
  type_exe2div_s exe2div_i;
  logic          pipe_stall_i;
  logic          kill_i;
  logic [31:0]   div_result_o;
  logic          div_done_o;
  logic          div_stall_o;

  int n_vec;
  int n_err;

  m_ext_divider dut (
    .rst_n       (rst_n),
    .clk         (clk),
    .exe2div_i   (exe2div_i),
    .pipe_stall_i(pipe_stall_i),
    .kill_i      (kill_i),
    .div_result_o(div_result_o),
    .div_done_o  (div_done_o),
    .div_stall_o (div_stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OpDiv:   return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
      OpDivu:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OpRem:   return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
      OpRemu:  return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    logic sgn;
    logic [31:0] ma, mb;
    sgn = (op == OpDiv) || (op == OpRem);
    ma  = (sgn && a[31]) ? -a : a;
    mb  = (sgn && b[31]) ? -b : b;
    if (b == 0) return 1;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 1;
`endif
    return (ma == mb) ? 33 : 33;
  endfunction

  task automatic gen(output logic [2:0] op, output logic [31:0] a, output logic [31:0] b);
    op = 3'($urandom_range(1, 4));
    a  = $urandom;
    if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
    case ($urandom_range(0, 5))
      0:       b = 32'h0;
      1:       b = 32'hFFFF_FFFF;
      2, 3:    b = 32'($urandom_range(1, 15));
      default: b = $urandom;
    endcase
  endtask

  // Issues one request at the current cycle (cycle 0) and follows it to completion.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit drop);
    logic [31:0] exp_r;
    int exp_lat;
    bit seen;
    exp_r = ref_result(op, a, b);
    exp_lat = ref_latency(op, a, b);
    seen = 1'b0;
    exe2div_i.alu_d_ops     = op;
    exe2div_i.alu_operand_1 = a;
    exe2div_i.alu_operand_2 = b;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (div_done_o) begin
        seen = 1'b1;
        n_vec++;
        if (c != exp_lat) begin
          n_err++;
          $display("FAIL latency op=%0d a=%h b=%h got %0d exp %0d", op, a, b, c, exp_lat);
        end
        n_vec++;
        if (div_result_o !== exp_r) begin
          n_err++;
          $display("FAIL result op=%0d a=%h b=%h got %h exp %h", op, a, b, div_result_o, exp_r);
        end
        n_vec++;
        if (div_stall_o !== 1'b0) begin
          n_err++;
          $display("FAIL stall_at_done got %b exp 0", div_stall_o);
        end
        @(posedge clk); #1;
        break;
      end
      n_vec++;
      if (div_stall_o !== 1'b1) begin
        n_err++;
        $display("FAIL stall_busy cycle %0d got %b exp 1", c, div_stall_o);
      end
      @(posedge clk); #1;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout op=%0d a=%h b=%h got no done exp done", op, a, b);
    end
    if (drop) begin
      exe2div_i.alu_d_ops = OpNone;
      @(negedge clk);
      n_vec++;
      if (div_done_o !== 1'b0 || div_stall_o !== 1'b0) begin
        n_err++;
        $display("FAIL after_done got done=%b stall=%b exp 0 0", div_done_o, div_stall_o);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    n_vec++;
    if (div_result_o !== 32'h0 || div_done_o !== 1'b0 || div_stall_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state got res=%h done=%b stall=%b exp 0 0 0",
               div_result_o, div_done_o, div_stall_o);
    end
  endtask

  task automatic test_directed();
    run_op(OpDivu, 32'd100, 32'd7, 1'b1);
    run_op(OpRemu, 32'd100, 32'd7, 1'b1);
    run_op(OpDiv, 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op(OpRem, 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op(OpRem, 32'd7, 32'hFFFF_FFFE, 1'b1);
    run_op(OpDiv, 32'd5, 32'd0, 1'b1);
    run_op(OpRemu, 32'd5, 32'd0, 1'b1);
    run_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op(OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op(OpDivu, 32'd3, 32'd10, 1'b1);
    run_op(OpDivu, 32'hFFFF_FFFF, 32'd1, 1'b1);
    run_op(OpRemu, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1);
    run_op(OpDiv, 32'h8000_0000, 32'd1, 1'b1);
  endtask

  task automatic test_none_codes();
    for (int k = 5; k < 8; k++) begin
      exe2div_i.alu_d_ops     = 3'(k);
      exe2div_i.alu_operand_1 = 32'd50;
      exe2div_i.alu_operand_2 = 32'd5;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        n_vec++;
        if (div_stall_o !== 1'b0 || div_done_o !== 1'b0) begin
          n_err++;
          $display("FAIL none_code %0d got stall=%b done=%b exp 0 0", k, div_stall_o, div_done_o);
        end
        @(posedge clk); #1;
      end
    end
    exe2div_i.alu_d_ops = OpNone;
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      gen(op, a, b);
      run_op(op, a, b, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 6; i++) begin
      gen(op, a, b);
      run_op(op, a, b, i == 5);
    end
  endtask

  task automatic test_kill();
    exe2div_i.alu_d_ops     = OpDivu;
    exe2div_i.alu_operand_1 = 32'hF000_0000 | $urandom;
    exe2div_i.alu_operand_2 = 32'($urandom_range(1, 255));
    for (int c = 0; c <= 10; c++) begin
      if (c == 10) kill_i = 1'b1;
      @(negedge clk);
      n_vec++;
      if (div_done_o !== 1'b0) begin
        n_err++;
        $display("FAIL kill_done cycle %0d got %b exp 0", c, div_done_o);
      end
      n_vec++;
      if (div_stall_o !== ((c < 10) ? 1'b1 : 1'b0)) begin
        n_err++;
        $display("FAIL kill_stall cycle %0d got %b exp %b", c, div_stall_o, c < 10);
      end
      @(posedge clk); #1;
    end
    kill_i = 1'b0;
    // Accepting 9/3 straight away with full latency shows the FSM was back in IDLE.
    run_op(OpDivu, 32'd9, 32'd3, 1'b1);
  endtask

  task automatic test_pipe_stall();
    logic [31:0] a, b, exp_r;
    bit seen;
    a = $urandom | 32'h0100_0000;
    b = 32'($urandom_range(2, 999));
    exp_r = ref_result(OpDivu, a, b);
    seen = 1'b0;
    exe2div_i.alu_d_ops     = OpDivu;
    exe2div_i.alu_operand_1 = a;
    exe2div_i.alu_operand_2 = b;
    pipe_stall_i = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (div_done_o) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL pipe_stall_timeout got no done exp done");
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (k > 0) @(negedge clk);
        n_vec++;
        if (div_done_o !== 1'b1) begin
          n_err++;
          $display("FAIL pipe_stall_done k=%0d got %b exp 1", k, div_done_o);
        end
        n_vec++;
        if (div_result_o !== exp_r) begin
          n_err++;
          $display("FAIL pipe_stall_result k=%0d got %h exp %h", k, div_result_o, exp_r);
        end
        @(posedge clk); #1;
        if (k == 2) pipe_stall_i = 1'b0;
      end
    end
    pipe_stall_i = 1'b0;
    exe2div_i.alu_d_ops = OpNone;
    @(negedge clk);
    n_vec++;
    if (div_done_o !== 1'b0) begin
      n_err++;
      $display("FAIL pipe_stall_release got %b exp 0", div_done_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_calc();
    run_op(OpDivu, 32'd1000, 32'd7, 1'b1);
    exe2div_i.alu_d_ops     = OpDivu;
    exe2div_i.alu_operand_1 = $urandom | 32'h8000_0000;
    exe2div_i.alu_operand_2 = 32'd3;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (div_result_o !== 32'h0 || div_done_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_calc got res=%h done=%b exp 0 0", div_result_o, div_done_o);
    end
    exe2div_i.alu_d_ops = OpNone;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(OpRem, 32'hFFFF_FF9C, 32'd7, 1'b1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    kill_i = 1'b0;
    pipe_stall_i = 1'b0;
    exe2div_i = '0;
    #12;
    test_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_directed();
    test_none_codes();
    test_kill();
    test_pipe_stall();
    test_random();
    test_back_to_back();
    test_reset_mid_calc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
